// File: rtl/term_writer.sv
// Byte-stream to strobe initiator for the VGA character terminal.
// Decodes cursor control codes and keeps a shadow of the terminal cursor.
//
//  state  | meaning
//  -------+----------------------------------------------------------
//  S_HOME | after reset: rstb 0x00 then cstb 0x00
//  S_IDLE | ready for a byte
//  S_XFER | single strobe transaction (SETUP/HIGH/HOLD phases)
//  S_SEQ  | multi-transaction sequence (BS or FF)
module term_writer #(
    parameter int SETUP = 1,
    parameter int PULSE = 2,
    parameter int HOLD  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] data,
    output logic       dstb,
    output logic       rstb,
    output logic       cstb,
    output logic [4:0] row,
    output logic [6:0] col,
    output logic       busy
);

    localparam logic [1:0] S_HOME = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_SEQ  = 2'd3;

    localparam logic [1:0] P_SETUP = 2'd0;
    localparam logic [1:0] P_HIGH  = 2'd1;
    localparam logic [1:0] P_HOLD  = 2'd2;

    localparam logic [1:0] K_D = 2'd0;
    localparam logic [1:0] K_R = 2'd1;
    localparam logic [1:0] K_C = 2'd2;

    localparam logic [7:0]  SETUP_LD = 8'(SETUP - 1);
    localparam logic [7:0]  PULSE_LD = 8'(PULSE - 1);
    localparam logic [7:0]  HOLD_LD  = 8'(HOLD - 1);
    localparam logic [11:0] FF_LAST  = 12'd2399;

    logic [1:0]  state, nxt_state;
    logic [1:0]  phase;
    logic [7:0]  cnt;
    logic [1:0]  kind;
    logic [7:0]  data_q;
    logic [4:0]  row_q;
    logic [6:0]  col_q;
    logic [1:0]  step, nxt_step;
    logic        seq_ff, nxt_seq_ff;
    logic [6:0]  bs_col, nxt_bs_col;
    logic [11:0] ff_cnt, nxt_ff_cnt;

    logic        ld;
    logic [1:0]  ld_kind;
    logic [7:0]  ld_data;
    logic        hold_done;
    logic [4:0]  row_inc;
    logic [7:0]  tab_sum, tab_col;
    logic [6:0]  col_dec;

    assign hold_done = (phase == P_HOLD) && (cnt == 8'd0);
    assign row_inc   = (row_q < 5'd29) ? row_q + 5'd1 : 5'd0;
    assign tab_sum   = {1'b0, col_q | 7'd7} + 8'd1;
    assign tab_col   = (tab_sum > 8'd79) ? 8'd79 : tab_sum;
    assign col_dec   = col_q - 7'd1;

    // Next transaction loads either on accept or in the final HOLD cycle of the previous one.
    always_comb begin
        nxt_state  = state;
        nxt_step   = step;
        nxt_seq_ff = seq_ff;
        nxt_bs_col = bs_col;
        nxt_ff_cnt = ff_cnt;
        ld         = 1'b0;
        ld_kind    = K_D;
        ld_data    = 8'h00;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    case (in_data)
                        8'h0D: begin ld = 1'b1; ld_kind = K_C; nxt_state = S_XFER; end
                        8'h0A: begin
                            ld = 1'b1; ld_kind = K_R; ld_data = {3'b000, row_inc};
                            nxt_state = S_XFER;
                        end
                        8'h09: begin ld = 1'b1; ld_kind = K_C; ld_data = tab_col; nxt_state = S_XFER; end
                        8'h08: begin
                            if (col_q != 7'd0) begin
                                ld = 1'b1; ld_kind = K_C; ld_data = {1'b0, col_dec};
                                nxt_state = S_SEQ; nxt_step = 2'd0; nxt_seq_ff = 1'b0;
                                nxt_bs_col = col_dec;
                            end
                        end
                        8'h0C: begin
                            ld = 1'b1; ld_kind = K_R;
                            nxt_state = S_SEQ; nxt_step = 2'd0; nxt_seq_ff = 1'b1;
                        end
                        default: begin ld = 1'b1; ld_kind = K_D; ld_data = in_data; nxt_state = S_XFER; end
                    endcase
                end
            end
            S_HOME: begin
                if (hold_done) begin
                    if (step == 2'd0) begin
                        ld = 1'b1; ld_kind = K_C; nxt_step = 2'd1;
                    end else begin
                        nxt_state = S_IDLE;
                    end
                end
            end
            S_XFER: begin
                if (hold_done) nxt_state = S_IDLE;
            end
            default: begin
                if (hold_done) begin
                    case (step)
                        2'd0: begin
                            ld = 1'b1; nxt_step = 2'd1;
                            ld_kind = seq_ff ? K_C : K_D;
                            ld_data = seq_ff ? 8'h00 : 8'h20;
                        end
                        2'd1: begin
                            ld = 1'b1; nxt_step = 2'd2;
                            ld_kind = seq_ff ? K_D : K_C;
                            ld_data = seq_ff ? 8'h20 : {1'b0, bs_col};
                            nxt_ff_cnt = FF_LAST;
                        end
                        default: begin
                            if (seq_ff && ff_cnt != 12'd0) begin
                                ld = 1'b1; ld_kind = K_D; ld_data = 8'h20;
                                nxt_ff_cnt = ff_cnt - 12'd1;
                            end else begin
                                nxt_state = S_IDLE;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_HOME;
            step   <= 2'd0;
            phase  <= P_SETUP;
            cnt    <= SETUP_LD;
            kind   <= K_R;
            data_q <= 8'h00;
            row_q  <= 5'd0;
            col_q  <= 7'd0;
            seq_ff <= 1'b0;
            bs_col <= 7'd0;
            ff_cnt <= 12'd0;
        end else begin
            state  <= nxt_state;
            step   <= nxt_step;
            seq_ff <= nxt_seq_ff;
            bs_col <= nxt_bs_col;
            ff_cnt <= nxt_ff_cnt;
            if (ld) begin
                phase  <= P_SETUP;
                cnt    <= SETUP_LD;
                kind   <= ld_kind;
                data_q <= ld_data;
            end else if (state != S_IDLE) begin
                if (cnt != 8'd0) begin
                    cnt <= cnt - 8'd1;
                end else begin
                    case (phase)
                        P_SETUP: begin
                            phase <= P_HIGH;
                            cnt   <= PULSE_LD;
                        end
                        P_HIGH: begin
                            phase <= P_HOLD;
                            cnt   <= HOLD_LD;
                            // Shadow cursor follows the terminal latching on the falling strobe.
                            case (kind)
                                K_D: begin
                                    if (col_q == 7'd79) begin
                                        col_q <= 7'd0;
                                        row_q <= row_inc;
                                    end else begin
                                        col_q <= col_q + 7'd1;
                                    end
                                end
                                K_R:     row_q <= data_q[4:0];
                                K_C:     col_q <= data_q[6:0];
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Reset forces the bus quiet in the very cycle it is asserted.
    always_comb begin
        in_ready = !reset && (state == S_IDLE);
        busy     = reset || (state != S_IDLE);
        dstb     = !reset && (state != S_IDLE) && (phase == P_HIGH) && (kind == K_D);
        rstb     = !reset && (state != S_IDLE) && (phase == P_HIGH) && (kind == K_R);
        cstb     = !reset && (state != S_IDLE) && (phase == P_HIGH) && (kind == K_C);
        data     = reset ? 8'h00 : data_q;
        row      = reset ? 5'd0 : row_q;
        col      = reset ? 7'd0 : col_q;
    end

endmodule

// File: tb/tb_term_writer.sv
// Directed bench for term_writer: HOME after reset, glyphs, control codes,
// cursor wrap, BS/FF sequences and reset during a form feed.
module tb_term_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data;
    logic       dstb, rstb, cstb;
    logic [4:0] row;
    logic [6:0] col;
    logic       busy;

    term_writer dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data     (data),
        .dstb     (dstb),
        .rstb     (rstb),
        .cstb     (cstb),
        .row      (row),
        .col      (col),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int n_d, n_r, n_c, n_busy, n_multi, n_bad20, n_plog;
    int last_d, last_r, last_c;
    int plog_kind[8];
    int plog_data[8];
    logic [7:0] tr_data[16];
    logic       tr_d[16], tr_r[16], tr_c[16], tr_rdy[16];
    logic [6:0] tr_col[16];

    int   n, rises;
    logic pd;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic log_pulse(input int k, input int d);
        if (n_plog < 8) begin
            plog_kind[n_plog] = k;
            plog_data[n_plog] = d;
        end
        n_plog++;
    endtask

    // Called just after a posedge; sample i covers cycle (accept + i). Returns the
    // index of the first cycle with in_ready high.
    task automatic watch(input int limit, output int cyc);
        logic pdd, prr, pcc;
        pdd = 1'b0; prr = 1'b0; pcc = 1'b0;
        n_d = 0; n_r = 0; n_c = 0; n_busy = 0; n_multi = 0; n_bad20 = 0; n_plog = 0;
        cyc = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (i < 16) begin
                tr_data[i] = data; tr_d[i] = dstb; tr_r[i] = rstb; tr_c[i] = cstb;
                tr_rdy[i] = in_ready; tr_col[i] = col;
            end
            if (dstb && !pdd) begin
                n_d++; last_d = data; log_pulse(1, data);
                if (data != 8'h20) n_bad20++;
            end
            if (rstb && !prr) begin n_r++; last_r = data; log_pulse(2, data); end
            if (cstb && !pcc) begin n_c++; last_c = data; log_pulse(3, data); end
            if ((dstb && rstb) || (dstb && cstb) || (rstb && cstb)) n_multi++;
            if (busy) n_busy++;
            pdd = dstb; prr = rstb; pcc = cstb;
            if (in_ready) begin
                cyc = i;
                break;
            end
            @(posedge clk); #1;
        end
        check("ready_seen", int'(cyc != 0), 1);
    endtask

    task automatic send(input logic [7:0] b, input int limit, output int cyc);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        check("accept_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'hA5;
        watch(limit, cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        // cycle 0: last cycle with reset high
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_rstb", rstb, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        watch(40, n);
        check("home_ready_cycle", n, 9);
        check("home_rstb_c1", tr_r[1], 0);
        check("home_rstb_c2", tr_r[2], 1);
        check("home_rstb_c3", tr_r[3], 1);
        check("home_rstb_c4", tr_r[4], 0);
        check("home_cstb_c5", tr_c[5], 0);
        check("home_cstb_c6", tr_c[6], 1);
        check("home_cstb_c7", tr_c[7], 1);
        check("home_data_c2", tr_data[2], 8'h00);
        check("home_data_c6", tr_data[6], 8'h00);
        check("home_rdy_c8", tr_rdy[8], 0);
        check("home_pulses_r", n_r, 1);
        check("home_pulses_c", n_c, 1);
        check("home_row", row, 0);
        check("home_col", col, 0);

        send(8'h41, 40, n);
        check("A_ready_cycle", n, 5);
        for (int i = 1; i <= 4; i++) check("A_data", tr_data[i], 8'h41);
        check("A_dstb_c1", tr_d[1], 0);
        check("A_dstb_c2", tr_d[2], 1);
        check("A_dstb_c3", tr_d[3], 1);
        check("A_dstb_c4", tr_d[4], 0);
        check("A_col_c3", tr_col[3], 0);
        check("A_col_c4", tr_col[4], 1);
        check("A_busy_cycles", n_busy, 4);

        send(8'h0D, 40, n);
        check("CR_cstb", n_c, 1);
        check("CR_data", last_c, 0);
        check("CR_col", col, 0);

        for (int i = 0; i < 29; i++) send(8'h0A, 40, n);
        check("LF29_data", last_r, 29);
        check("LF29_row", row, 29);

        for (int i = 0; i < 10; i++) send(8'h09, 40, n);
        check("TAB10_data", last_c, 79);
        check("TAB10_col", col, 79);

        send(8'h5A, 40, n);
        check("Z_dstb", n_d, 1);
        check("Z_data", last_d, 8'h5A);
        check("Z_wrap_row", row, 0);
        check("Z_wrap_col", col, 0);

        for (int i = 0; i < 29; i++) send(8'h0A, 40, n);
        check("LF_to29_row", row, 29);
        send(8'h0A, 40, n);
        check("LF_wrap_data", last_r, 0);
        check("LF_wrap_row", row, 0);

        send(8'h08, 40, n);
        check("BS0_ready_cycle", n, 1);
        check("BS0_pulses", n_d + n_r + n_c, 0);
        check("BS0_col", col, 0);

        send(8'h61, 40, n);
        send(8'h62, 40, n);
        send(8'h63, 40, n);
        send(8'h64, 40, n);
        send(8'h65, 40, n);
        check("glyphs_col", col, 5);
        send(8'h08, 40, n);
        check("BS5_ready_cycle", n, 13);
        check("BS5_npulses", n_plog, 3);
        check("BS5_p0_kind", plog_kind[0], 3);
        check("BS5_p0_data", plog_data[0], 8'h04);
        check("BS5_p1_kind", plog_kind[1], 1);
        check("BS5_p1_data", plog_data[1], 8'h20);
        check("BS5_p2_kind", plog_kind[2], 3);
        check("BS5_p2_data", plog_data[2], 8'h04);
        check("BS5_col_c12", tr_col[12], 4);
        check("BS5_col", col, 4);

        send(8'h0C, 12000, n);
        check("FF_ready_cycle", n, 9609);
        check("FF_busy_cycles", n_busy, 9608);
        check("FF_dstb_pulses", n_d, 2400);
        check("FF_rstb_pulses", n_r, 1);
        check("FF_cstb_pulses", n_c, 1);
        check("FF_dstb_data", n_bad20, 0);
        check("FF_first_kind", plog_kind[0], 2);
        check("FF_second_kind", plog_kind[1], 3);
        check("FF_one_strobe", n_multi, 0);
        check("FF_row", row, 0);
        check("FF_col", col, 0);

        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'h0C;
        @(negedge clk);
        check("FFr_accept_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rises = 0;
        pd = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (dstb && !pd) rises++;
            pd = dstb;
            if (rises == 1000) break;
            @(posedge clk); #1;
        end
        check("FFr_pulse1000", rises, 1000);
        // second high cycle of pulse #1000: assert reset mid-pulse
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("FFr_dstb_low", dstb, 0);
        check("FFr_data_zero", data, 0);
        check("FFr_row_zero", row, 0);
        check("FFr_col_zero", col, 0);
        check("FFr_in_ready", in_ready, 0);
        check("FFr_busy", busy, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        watch(40, n);
        check("FFr_ready_cycle", n, 9);
        check("FFr_c1_data", tr_data[1], 0);
        check("FFr_c1_col", tr_col[1], 0);
        check("FFr_c1_rdy", tr_rdy[1], 0);
        check("FFr_c1_strobes", int'(tr_d[1]) + int'(tr_r[1]) + int'(tr_c[1]), 0);
        check("FFr_dstb_after", n_d, 0);
        check("FFr_rstb_after", n_r, 1);
        check("FFr_cstb_after", n_c, 1);
        check("FFr_row", row, 0);
        check("FFr_col", col, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
